// File: rtl/fetch_sequencer.sv
// fetch_sequencer: MIPS IF-stage PC sequencing, imem handshake, one-entry skid buffer, redirect flush.
// Optional FETCH_TIMEOUT_EN builds the wait counter and sticky fetch_timeout flag.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_timeout
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [31:0] drain_addr, skid_data, skid_pc, target;
  logic skid_valid, redirect;
  assign redirect = branch_taken | jump;
  assign target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
  assign imem_req = state == FETCH || state == DRAIN;
  // DRAIN keeps the abandoned request's address stable until memory answers
  assign imem_addr = state == DRAIN ? drain_addr : pc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      drain_addr <= '0;
      skid_data <= '0;
      skid_pc <= '0;
      skid_valid <= 1'b0;
      inst <= '0;
      inst_pc <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) begin
            pc <= target;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
          end
        end
        FETCH:
          if (redirect) begin
            pc <= target;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
            if (!imem_ready) begin
              state <= DRAIN;
              drain_addr <= pc;
            end
          end else if (imem_ready) begin
            pc <= pc + 32'd4;
            if (stall) begin
              skid_data <= imem_rdata;
              skid_pc <= pc;
              skid_valid <= 1'b1;
              state <= HOLD;
            end else begin
              inst <= imem_rdata;
              inst_pc <= pc;
              inst_valid <= 1'b1;
            end
          end
        HOLD:
          if (redirect) begin
            pc <= target;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
            state <= FETCH;
          end else if (!stall) begin
            inst <= skid_data;
            inst_pc <= skid_pc;
            inst_valid <= skid_valid;
            skid_valid <= 1'b0;
            state <= FETCH;
          end
        default: begin
          if (redirect) pc <= target;
          if (imem_ready) state <= FETCH;
        end
      endcase
    end
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wait_cnt <= '0;
      fetch_timeout <= 1'b0;
    end else if (imem_req) begin
      if (imem_ready) wait_cnt <= '0;
      else begin
        if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + CW'(1);
        if (wait_cnt == CW'(MAX_WAIT - 1)) fetch_timeout <= 1'b1;
      end
    end
`else
  // MAX_WAIT only matters when the counter is built; this expression is constant 0
  assign fetch_timeout = MAX_WAIT < 0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven checks of fetch_sequencer plus reset and timeout sequences.
module tb_fetch_sequencer;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, imem_rdata = '0;
  logic imem_req, inst_valid, fetch_timeout;
  logic [31:0] imem_addr, pc, inst, inst_pc;
  int checks = 0, errors = 0;
  localparam logic [31:0] D = 32'hA000_0000;
`ifdef FETCH_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif
  typedef struct {
    logic s, b; logic [31:0] bt; logic j; logic [31:0] jt; logic r; logic [31:0] rd;
    logic ereq; logic [31:0] eaddr, epc, einst, eipc; logic ev;
  } vec_t;
  vec_t v[31];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
      logic r, logic [31:0] rd, logic ereq, logic [31:0] eaddr, logic [31:0] epc,
      logic [31:0] einst, logic [31:0] eipc, logic ev);
    vec_t t;
    t.s = s; t.b = b; t.bt = bt; t.j = j; t.jt = jt; t.r = r; t.rd = rd;
    t.ereq = ereq; t.eaddr = eaddr; t.epc = epc; t.einst = einst; t.eipc = eipc; t.ev = ev;
    return t;
  endfunction

  initial begin
    v[0]  = mk(0,0,0,0,0, 1,0,          0,0,      0,      0,       0,      0);
    v[1]  = mk(0,0,0,0,0, 1,D+0,        1,0,      4,      D+0,     0,      1);
    v[2]  = mk(0,0,0,0,0, 1,D+4,        1,4,      8,      D+4,     4,      1);
    v[3]  = mk(0,0,0,0,0, 1,D+8,        1,8,      'hC,    D+8,     8,      1);
    v[4]  = mk(0,0,0,0,0, 0,0,          1,'hC,    'hC,    D+8,     8,      1);
    v[5]  = v[4];
    v[6]  = v[4];
    v[7]  = mk(0,0,0,0,0, 1,D+'hC,      1,'hC,    'h10,   D+'hC,   'hC,    1);
    v[8]  = mk(1,0,0,0,0, 1,D+'h10,     1,'h10,   'h14,   D+'hC,   'hC,    1);
    v[9]  = mk(1,0,0,0,0, 0,0,          0,'h14,   'h14,   D+'hC,   'hC,    1);
    v[10] = v[9];
    v[11] = v[9];
    v[12] = mk(0,0,0,0,0, 0,0,          0,'h14,   'h14,   D+'h10,  'h10,   1);
    v[13] = mk(0,0,0,0,0, 1,D+'h14,     1,'h14,   'h18,   D+'h14,  'h14,   1);
    v[14] = mk(0,0,0,0,0, 1,D+'h18,     1,'h18,   'h1C,   D+'h18,  'h18,   1);
    v[15] = mk(0,0,0,0,0, 1,D+'h1C,     1,'h1C,   'h20,   D+'h1C,  'h1C,   1);
    v[16] = mk(0,0,0,0,0, 0,0,          1,'h20,   'h20,   D+'h1C,  'h1C,   1);
    v[17] = mk(0,1,'h103,0,0, 0,0,      1,'h20,   'h100,  D+'h1C,  'h1C,   0);
    v[18] = mk(0,0,0,0,0, 0,0,          1,'h20,   'h100,  D+'h1C,  'h1C,   0);
    v[19] = mk(0,0,0,0,0, 1,D+'h20,     1,'h20,   'h100,  D+'h1C,  'h1C,   0);
    v[20] = mk(0,0,0,0,0, 1,D+'h100,    1,'h100,  'h104,  D+'h100, 'h100,  1);
    v[21] = mk(1,1,'h40,1,'h80, 1,D+'h104, 1,'h104, 'h40,  D+'h100, 'h100,  0);
    v[22] = mk(0,0,0,0,0, 1,D+'h40,     1,'h40,   'h44,   D+'h40,  'h40,   1);
    v[23] = mk(0,0,0,1,'h203, 0,0,      1,'h44,   'h200,  D+'h40,  'h40,   0);
    v[24] = mk(0,1,'h300,0,0, 1,'hDEAD, 1,'h44,   'h300,  D+'h40,  'h40,   0);
    v[25] = mk(0,0,0,0,0, 1,D+'h300,    1,'h300,  'h304,  D+'h300, 'h300,  1);
    v[26] = mk(0,0,0,1,'hFFFF_FFFC, 1,'hBAD, 1,'h304, 'hFFFF_FFFC, D+'h300, 'h300, 0);
    v[27] = mk(0,0,0,0,0, 1,'h5EED_0001, 1,'hFFFF_FFFC, 0, 'h5EED_0001, 'hFFFF_FFFC, 1);
    v[28] = mk(1,0,0,0,0, 1,D+0,        1,0,      4,      'h5EED_0001, 'hFFFF_FFFC, 1);
    v[29] = mk(1,1,'h500,0,0, 0,0,      0,4,      'h500,  'h5EED_0001, 'hFFFF_FFFC, 0);
    v[30] = mk(0,0,0,0,0, 1,D+'h500,    1,'h500,  'h504,  D+'h500, 'h500,  1);
    step();
    step();
    chk("reset_pc", pc, 0);
    chk("reset_req", {31'd0, imem_req}, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_inst", inst, 0);
    chk("reset_inst_pc", inst_pc, 0);
    chk("reset_valid", {31'd0, inst_valid}, 0);
    chk("reset_timeout", {31'd0, fetch_timeout}, 0);
    reset = 1'b1;
    for (int i = 0; i < 31; i++) begin
      stall = v[i].s; branch_taken = v[i].b; branch_target = v[i].bt;
      jump = v[i].j; jump_target = v[i].jt; imem_ready = v[i].r; imem_rdata = v[i].rd;
      #1;
      chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, v[i].ereq});
      chk($sformatf("row%0d_addr", i), imem_addr, v[i].eaddr);
      step();
      chk($sformatf("row%0d_pc", i), pc, v[i].epc);
      chk($sformatf("row%0d_inst", i), inst, v[i].einst);
      chk($sformatf("row%0d_inst_pc", i), inst_pc, v[i].eipc);
      chk($sformatf("row%0d_valid", i), {31'd0, inst_valid}, {31'd0, v[i].ev});
      chk($sformatf("row%0d_timeout", i), {31'd0, fetch_timeout}, 0);
    end
    stall = 0; branch_taken = 0; jump = 0; imem_ready = 0;
    step();
    chk("midreq_req", {31'd0, imem_req}, 1);
    chk("midreq_addr", imem_addr, 'h504);
    reset = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, imem_req}, 0);
    chk("async_pc", pc, 0);
    chk("async_valid", {31'd0, inst_valid}, 0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 14; i++) step();
    chk("to_before_15", {31'd0, fetch_timeout}, 0);
    chk("to_wait_addr", imem_addr, 0);
    step();
    chk("to_at_15", {31'd0, fetch_timeout}, {31'd0, TO_EXP});
    imem_ready = 1; imem_rdata = 'h1234_5678;
    step();
    imem_ready = 0;
    chk("to_sticky", {31'd0, fetch_timeout}, {31'd0, TO_EXP});
    chk("to_done_inst", inst, 'h1234_5678);
    chk("to_done_pc", pc, 4);
    step();
    step();
    chk("to_still_sticky", {31'd0, fetch_timeout}, {31'd0, TO_EXP});
    reset = 1'b0;
    #1;
    chk("to_reset_clear", {31'd0, fetch_timeout}, 0);
    chk("to_reset_pc", pc, 0);
    reset = 1'b1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
